// File: rtl/bus_arbiter_rr8_if.sv
// Bundle of request/grant signals between the 8 bus sources and the
// round-robin arbiter that drives the decoder3_8 + bufif1 select fabric.
//   req    : one request bit per source (bit i = source i)
//   gnt    : one-hot registered grant back to each source
//   sel    : registered index of the granted source (decoder s2..s0)
//   bus_en : registered, high while a grant is active (decoder gate)
//   busy   : combinational bus_en | (|req)
// Modports: master = requester side, slave = arbiter side.
interface bus_arbiter_rr8_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       bus_en;
  logic       busy;

  modport master (
    output req,
    input  gnt,
    input  sel,
    input  bus_en,
    input  busy
  );

  modport slave (
    input  req,
    output gnt,
    output sel,
    output bus_en,
    output busy
  );
endinterface

// File: rtl/bus_arbiter_rr8.sv
// Round-robin arbiter for an 8-source shared tri-state bus.
// Registers a 3-bit select and bus enable for the decoder plus a one-hot
// grant per requester. A bounded hold time (MAX_HOLD) forces the owner off
// the bus when someone else is waiting; MAX_HOLD = 0 disables preemption.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : bus_arbiter_rr8_if.slave (req in; gnt, sel, bus_en, busy out)
// Optional feature macro ARB_TURNAROUND_EN: every release or preempt
// passes through one dead TURN cycle (gnt=0, bus_en=0, sel held) before
// the next winner is chosen, so two bufif1 drivers never overlap.
// Parameters:
//   MAX_HOLD : max consecutive grant cycles while another source waits
//   CNT_W    : hold-counter width, 2**CNT_W > MAX_HOLD
module bus_arbiter_rr8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  bus_arbiter_rr8_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  // Last hold count before a waiting source forces a handoff; with
  // preemption disabled the counter just saturates at all-ones.
  localparam logic [CNT_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '1 : CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic             bus_en_q, bus_en_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic [7:0] others;
  logic       any_req;
  logic       rel_c;
  logic       preempt_c;
  logic [2:0] win_idle;
  logic [2:0] win_hand;

  // First set bit of r searching upward from ptr+1, wrapping 7 -> 0.
  // Returns ptr when r is empty; callers only use it when r is non-zero.
  function automatic logic [2:0] rr_pick(input logic [7:0] r,
                                         input logic [2:0] ptr);
    logic [2:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned i = 1; i <= 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // While granted rr_ptr equals the owner, so searching from rr_ptr+1 over
  // the owner-masked requests yields the next source in round-robin order.
  always_comb begin
    others    = bus.req & ~(8'b1 << sel_q);
    any_req   = |bus.req;
    rel_c     = ~bus.req[sel_q];
    preempt_c = (MAX_HOLD != 0) && (hold_q == HOLD_LAST) && (|others);
    win_idle  = rr_pick(bus.req, rr_ptr_q);
    win_hand  = rr_pick(others, rr_ptr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      bus_en_q <= 1'b0;
      gnt_q    <= '0;
      rr_ptr_q <= 3'd7;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      bus_en_q <= bus_en_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req) state_d = GRANT;
      end
      GRANT: begin
        if (rel_c || preempt_c) begin
`ifdef ARB_TURNAROUND_EN
          state_d = TURN;
`else
          state_d = (|others) ? GRANT : IDLE;
`endif
        end
      end
      TURN: begin
        state_d = any_req ? GRANT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d    = sel_q;
    bus_en_d = bus_en_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    case (state_q)
      IDLE, TURN: begin
        if (any_req) begin
          sel_d    = win_idle;
          bus_en_d = 1'b1;
          rr_ptr_d = win_idle;
          hold_d   = '0;
        end
      end
      GRANT: begin
        if (rel_c || preempt_c) begin
`ifdef ARB_TURNAROUND_EN
          bus_en_d = 1'b0;
          hold_d   = '0;
`else
          if (|others) begin
            sel_d    = win_hand;
            bus_en_d = 1'b1;
            rr_ptr_d = win_hand;
            hold_d   = '0;
          end else begin
            bus_en_d = 1'b0;
            hold_d   = '0;
          end
`endif
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        bus_en_d = 1'b0;
        hold_d   = '0;
      end
    endcase
    // gnt is derived from the same next values so it always matches sel/bus_en.
    gnt_d = bus_en_d ? (8'b1 << sel_d) : 8'h00;
  end

  assign bus.gnt    = gnt_q;
  assign bus.sel    = sel_q;
  assign bus.bus_en = bus_en_q;
  assign bus.busy   = bus_en_q | any_req;

endmodule

// File: tb/tb_bus_arbiter_rr8.sv
module tb_bus_arbiter_rr8;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  bus_arbiter_rr8_if bus ();

  bus_arbiter_rr8 #(.MAX_HOLD(MH), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner index (-1 = nobody on the bus), number of
  // cycles the owner has held the bus, last owner for round-robin order.
  int         m_owner = -1;
  int         m_held  = 0;
  int         m_last  = 7;
  int         m_sel   = 0;
  int         m_next;
  logic [7:0] m_req;
  logic [7:0] m_others;

  function automatic int pick(input logic [7:0] r, input int from);
    for (int i = 1; i <= 8; i++) begin
      if (r[(from + i) % 8]) return (from + i) % 8;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_held = 0; m_last = 7; m_sel = 0;
    end else begin
      m_req = bus.req;
      if (m_owner < 0) begin
        m_next = pick(m_req, m_last);
        if (m_next >= 0) begin
          m_owner = m_next; m_last = m_next; m_sel = m_next; m_held = 1;
        end
      end else begin
        m_others = m_req;
        m_others[m_owner] = 1'b0;
        if (!m_req[m_owner] || (MH != 0 && m_held >= MH && m_others != 0)) begin
`ifdef ARB_TURNAROUND_EN
          m_owner = -1;
`else
          m_next = pick(m_others, m_last);
          if (m_next >= 0) begin
            m_owner = m_next; m_last = m_next; m_sel = m_next; m_held = 1;
          end else begin
            m_owner = -1;
          end
`endif
        end else if (m_held < 1000) begin
          m_held++;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_gnt", bus.gnt, (m_owner < 0) ? 8'h00 : (8'h01 << m_owner));
    chk("model_sel", {5'b0, bus.sel}, 8'(m_sel));
    chk("model_bus_en", {7'b0, bus.bus_en}, {7'b0, m_owner >= 0});
    chk("model_busy", {7'b0, bus.busy}, {7'b0, (m_owner >= 0) || (|bus.req)});
  end

  task automatic step(input logic [7:0] r);
    #1 bus.req = r;
    @(negedge clk);
  endtask

  initial begin
    bus.req = 8'h00;
    // Reset held with no requests
    repeat (5) begin
      @(negedge clk);
      chk("rst_gnt", bus.gnt, 8'h00);
      chk("rst_sel", {5'b0, bus.sel}, 8'h00);
      chk("rst_bus_en", {7'b0, bus.bus_en}, 8'h00);
      chk("rst_busy", {7'b0, bus.busy}, 8'h00);
    end
    #1 rst_n = 1'b1;

    // Two requesters, release ordering
    step(8'h81);
    chk("t2_gnt0", bus.gnt, 8'h01);
    chk("t2_sel0", {5'b0, bus.sel}, 8'h00);
    step(8'h80);
    chk("t2_gnt7", bus.gnt, 8'h80);
    chk("t2_sel7", {5'b0, bus.sel}, 8'h07);
    step(8'h00);
    chk("t2_idle", bus.gnt, 8'h00);
    chk("t2_idle_en", {7'b0, bus.bus_en}, 8'h00);

    // All requesting: each grant lasts MH cycles, 80 wraps back to 01
    for (int k = 0; k <= 8 * MH; k++) begin
      step(8'hFF);
`ifndef ARB_TURNAROUND_EN
      chk("t3_rotate", bus.gnt, 8'h01 << ((k / MH) % 8));
`endif
    end
    step(8'h00);
`ifndef ARB_TURNAROUND_EN
    chk("t3_release", bus.gnt, 8'h00);
`endif

    // Lone requester keeps the bus well past MH
    step(8'h08);
    chk("t4_first", bus.gnt, 8'h08);
    for (int k = 0; k < 40; k++) begin
      step(8'h08);
      chk("t4_hold", bus.gnt, 8'h08);
    end
    step(8'h00);

    // Async reset during a grant on source 5
    step(8'h20);
    chk("t5_gnt5", bus.gnt, 8'h20);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_gnt", bus.gnt, 8'h00);
    chk("t5_async_en", {7'b0, bus.bus_en}, 8'h00);
    chk("t5_async_sel", {5'b0, bus.sel}, 8'h00);
    @(negedge clk);
    #1 rst_n = 1'b1;
    bus.req = 8'h24;
    @(negedge clk);
    chk("t5_restart", bus.gnt, 8'h04);
    step(8'h00);

    // Handoff 0 -> 1 on release
    step(8'h03);
    chk("t6_gnt0", bus.gnt, 8'h01);
    step(8'h02);
`ifdef ARB_TURNAROUND_EN
    chk("t6_turn_gnt", bus.gnt, 8'h00);
    chk("t6_turn_en", {7'b0, bus.bus_en}, 8'h00);
    step(8'h02);
`endif
    chk("t6_gnt1", bus.gnt, 8'h02);

    // Non-owner churn below the hold limit does not disturb the owner
    step(8'h06);
    chk("t7_keep", bus.gnt, 8'h02);
    step(8'h0A);
    chk("t7_keep2", bus.gnt, 8'h02);
    step(8'h00);
    step(8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
